// File: rtl/imem_boot_loader.sv
// imem_boot_loader: framed byte-stream loader for the core instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module imem_boot_loader #(
   parameter int unsigned MAX_WORDS      = 256,
   parameter int unsigned TIMEOUT_CYCLES = 65536
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [31:0] write_inst,
   output logic        inst_mem_write_en,
   output logic [31:0] write_addr,
   output logic        core_hold,
   output logic        load_done,
   output logic        load_error,
   output logic [1:0]  error_code
);

   localparam logic [7:0]  SYNC      = 8'hA5;
   localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LIM  = TW'(TIMEOUT_CYCLES);
   localparam logic [16:0] MAX_W     = 17'(MAX_WORDS);
   localparam logic [1:0]  ERR_NONE  = 2'd0;
   localparam logic [1:0]  ERR_LEN   = 2'd1;
   localparam logic [1:0]  ERR_TIME  = 2'd3;
`ifdef LOADER_CHECKSUM_EN
   localparam logic [1:0]  ERR_CKSUM = 2'd2;
`endif

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_LO = 3'd1,
      S_LEN_HI = 3'd2,
      S_DATA   = 3'd3,
`ifdef LOADER_CHECKSUM_EN
      S_CHECK  = 3'd4,
`endif
      S_DONE   = 3'd5,
      S_ERROR  = 3'd6
   } state_t;

   state_t         state_q;
   logic [7:0]     len_lo_q;
   logic [15:0]    n_q;
   logic [15:0]    word_idx_q;
   logic [1:0]     byte_idx_q;
   logic [23:0]    buf_q;
   logic [TW-1:0]  idle_q;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]     cks_q;
   logic [7:0]     cks_d;
`endif

   logic           rx_ready_q;
   logic           wr_en_q;
   logic [31:0]    wr_data_q;
   logic [31:0]    wr_addr_q;
   logic           hold_q;
   logic           done_q;
   logic           err_q;
   logic [1:0]     code_q;

   logic           accept;
   logic           timer_on;
   logic           timeout;
   logic [15:0]    len_d;
   logic           len_bad;
   logic           last_word;
   logic [31:0]    word_d;
   logic [31:0]    addr_d;

   assign accept    = rx_valid & rx_ready_q;
   assign len_d     = {rx_data, len_lo_q};
   assign len_bad   = (len_d == 16'd0) | ({1'b0, len_d} > MAX_W);
   assign last_word = (word_idx_q == n_q - 16'd1);
   assign word_d    = {rx_data, buf_q};
   assign addr_d    = {14'b0, word_idx_q, 2'b00};
`ifdef LOADER_CHECKSUM_EN
   assign cks_d     = cks_q ^ rx_data;
`endif

   always_comb begin
      timer_on = 1'b0;
      unique case (state_q)
         S_LEN_LO, S_LEN_HI, S_DATA: timer_on = 1'b1;
`ifdef LOADER_CHECKSUM_EN
         S_CHECK:                    timer_on = 1'b1;
`endif
         default:                    timer_on = 1'b0;
      endcase
   end

   // The abort wins over a byte offered on the same edge.
   assign timeout = timer_on & (idle_q == TO_LIM);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         len_lo_q   <= '0;
         n_q        <= '0;
         word_idx_q <= '0;
         byte_idx_q <= '0;
         buf_q      <= '0;
         idle_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
         cks_q      <= '0;
`endif
         rx_ready_q <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_data_q  <= '0;
         wr_addr_q  <= '0;
         hold_q     <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         code_q     <= ERR_NONE;
      end else begin
         rx_ready_q <= 1'b1;
         wr_en_q    <= 1'b0;
         idle_q     <= (timer_on && !accept) ? idle_q + TW'(1) : '0;
         if (timeout) begin
            state_q <= S_ERROR;
            err_q   <= 1'b1;
            code_q  <= ERR_TIME;
         end else if (accept) begin
            unique case (state_q)
               S_IDLE: begin
                  if (rx_data == SYNC) state_q <= S_LEN_LO;
               end
               S_LEN_LO: begin
                  len_lo_q <= rx_data;
                  state_q  <= S_LEN_HI;
               end
               S_LEN_HI: begin
                  if (len_bad) begin
                     state_q <= S_ERROR;
                     err_q   <= 1'b1;
                     code_q  <= ERR_LEN;
                  end else begin
                     n_q        <= len_d;
                     word_idx_q <= '0;
                     byte_idx_q <= '0;
`ifdef LOADER_CHECKSUM_EN
                     cks_q      <= '0;
`endif
                     state_q    <= S_DATA;
                  end
               end
               S_DATA: begin
                  buf_q      <= {rx_data, buf_q[23:8]};
                  byte_idx_q <= byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                  cks_q      <= cks_d;
`endif
                  if (byte_idx_q == 2'd3) begin
                     wr_en_q    <= 1'b1;
                     wr_data_q  <= word_d;
                     wr_addr_q  <= addr_d;
                     word_idx_q <= word_idx_q + 16'd1;
                     if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        state_q <= S_CHECK;
`else
                        state_q <= S_DONE;
                        hold_q  <= 1'b0;
                        done_q  <= 1'b1;
`endif
                     end
                  end
               end
`ifdef LOADER_CHECKSUM_EN
               S_CHECK: begin
                  if (rx_data == cks_q) begin
                     state_q <= S_DONE;
                     hold_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_ERROR;
                     err_q   <= 1'b1;
                     code_q  <= ERR_CKSUM;
                  end
               end
`endif
               S_DONE, S_ERROR: begin
                  if (rx_data == SYNC) begin
                     state_q <= S_LEN_LO;
                     hold_q  <= 1'b1;
                     done_q  <= 1'b0;
                     err_q   <= 1'b0;
                     code_q  <= ERR_NONE;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign rx_ready          = rx_ready_q;
   assign inst_mem_write_en = wr_en_q;
   assign write_inst        = wr_data_q;
   assign write_addr        = wr_addr_q;
   assign core_hold         = hold_q;
   assign load_done         = done_q;
   assign load_error        = err_q;
   assign error_code        = code_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: vector table plus hand-written corner sequences.
// Expected writes go to a queue when a word's last byte is driven.
module tb_imem_boot_loader;

   localparam int MAXW = 4;
   localparam int TO   = 20;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [31:0] write_inst;
   logic        inst_mem_write_en;
   logic [31:0] write_addr;
   logic        core_hold;
   logic        load_done;
   logic        load_error;
   logic [1:0]  error_code;

   imem_boot_loader #(
      .MAX_WORDS(MAXW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .write_inst(write_inst),
      .inst_mem_write_en(inst_mem_write_en),
      .write_addr(write_addr),
      .core_hold(core_hold),
      .load_done(load_done),
      .load_error(load_error),
      .error_code(error_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        done;
      logic        err;
      logic [1:0]  code;
      logic        hold;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] word;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] word;
   } wr_t;

   vec_t tbl[$];
   wr_t  exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

`ifdef LOADER_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   function automatic vec_t mk(input logic v, input logic [7:0] d,
                               input logic done, input logic err,
                               input logic [1:0] code, input logic hold,
                               input logic wr, input logic [31:0] addr,
                               input logic [31:0] word);
      vec_t t;
      t.v = v; t.d = d; t.done = done; t.err = err; t.code = code;
      t.hold = hold; t.wr = wr; t.addr = addr; t.word = word;
      return t;
   endfunction

   task automatic busy(input logic [7:0] d);
      tbl.push_back(mk(1'b1, d, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 0, 0));
   endtask
   task automatic bub();
      tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 0, 0));
   endtask
   task automatic done(input logic [7:0] d);
      tbl.push_back(mk(1'b1, d, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 0, 0));
   endtask
   task automatic err(input logic [7:0] d, input logic [1:0] c);
      tbl.push_back(mk(1'b1, d, 1'b0, 1'b1, c, 1'b1, 1'b0, 0, 0));
   endtask
   task automatic wr(input logic [7:0] d, input logic [31:0] a,
                     input logic [31:0] w, input logic fin);
      tbl.push_back(mk(1'b1, d, fin, 1'b0, 2'd0, !fin, 1'b1, a, w));
   endtask

   task automatic step(input vec_t t);
      logic [6:0] got;
      logic [6:0] want;
      wr_t        e;
      rx_valid = t.v;
      rx_data  = t.d;
      if (t.wr) begin
         e.addr = t.addr;
         e.word = t.word;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      got  = {rx_ready, inst_mem_write_en, load_done, load_error,
              error_code, core_hold};
      want = {1'b1, t.wr, t.done, t.err, t.code, t.hold};
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL status byte=%h got rdy/we/done/err/code/hold=%b want=%b",
                  t.d, got, want);
      end
      if (inst_mem_write_en === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL write unexpected addr=%h data=%h",
                     write_addr, write_inst);
         end else begin
            e = exp_q.pop_front();
            if (write_addr !== e.addr || write_inst !== e.word) begin
               n_fail++;
               $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                        write_addr, write_inst, e.addr, e.word);
            end
         end
      end
   endtask

   task automatic chk_reset(input string nm);
      logic [100:0] got;
      logic [100:0] want;
      got  = {rx_ready, core_hold, inst_mem_write_en, write_inst, write_addr,
              load_done, load_error, error_code};
      want = {1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0};
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endtask

   task automatic frame1w(input logic [7:0] ck);
      step(mk(1'b1, 8'h01, 0, 0, 2'd0, 1, 0, 0, 0));
      step(mk(1'b1, 8'h00, 0, 0, 2'd0, 1, 0, 0, 0));
      step(mk(1'b1, 8'h13, 0, 0, 2'd0, 1, 0, 0, 0));
      step(mk(1'b1, 8'h00, 0, 0, 2'd0, 1, 0, 0, 0));
      step(mk(1'b1, 8'h00, 0, 0, 2'd0, 1, 0, 0, 0));
      step(mk(1'b1, 8'h00, !CK, 0, 2'd0, CK, 1, 0, 32'h13));
      if (CK) step(mk(1'b1, ck, 1, 0, 2'd0, 0, 0, 0, 0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      logic [7:0]  cks;
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk_reset("reset_state");
      reset = 1'b0;

      // two-word frame with idle discards and bubbles
      busy(8'h00); busy(8'h5A);
      busy(8'hA5); busy(8'h02); bub(); busy(8'h00);
      busy(8'h13); busy(8'h00); bub(); busy(8'h00);
      wr(8'h00, 32'd0, 32'h0000_0013, 1'b0);
      busy(8'h93); busy(8'h00); busy(8'h10);
      wr(8'h00, 32'd4, 32'h0010_0093, !CK);
      if (CK) done(8'h90);
      done(8'h00);
      // bad lengths: zero, MAX+1, high byte set
      busy(8'hA5); busy(8'h00); err(8'h00, 2'd1); err(8'h55, 2'd1);
      busy(8'hA5); busy(8'(MAXW + 1)); err(8'h00, 2'd1);
      busy(8'hA5); busy(8'h01); err(8'h01, 2'd1);
      // exactly MAX_WORDS words
      busy(8'hA5); busy(8'(MAXW)); busy(8'h00);
      cks = 8'h00;
      for (int k = 0; k < MAXW; k++) begin
         w = 32'hA1B2_C3D0 + 32'(k * 5);
         cks = cks ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
         busy(w[7:0]); busy(w[15:8]); busy(w[23:16]);
         wr(w[31:24], 32'(4 * k), w, (k == MAXW - 1) && !CK);
      end
      if (CK) done(cks);
      // one-word frame: bad checksum then recovery, or trailing discard
      busy(8'hA5); busy(8'h01); busy(8'h00);
      busy(8'h13); busy(8'h00); busy(8'h00);
      wr(8'h00, 32'd0, 32'h13, !CK);
      if (CK) begin
         err(8'h00, 2'd2);
         busy(8'hA5); busy(8'h01); busy(8'h00);
         busy(8'h13); busy(8'h00); busy(8'h00);
         wr(8'h00, 32'd0, 32'h13, 1'b0);
         done(8'h13);
      end else begin
         done(8'h55);
      end

      for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

      // timeout after two data bytes; the byte on the abort edge is dropped
      step(mk(1'b1, 8'hA5, 0, 0, 2'd0, 1, 0, 0, 0));
      step(mk(1'b1, 8'h01, 0, 0, 2'd0, 1, 0, 0, 0));
      step(mk(1'b1, 8'h00, 0, 0, 2'd0, 1, 0, 0, 0));
      step(mk(1'b1, 8'h13, 0, 0, 2'd0, 1, 0, 0, 0));
      step(mk(1'b1, 8'h00, 0, 0, 2'd0, 1, 0, 0, 0));
      for (int i = 0; i < TO; i++)
         step(mk(1'b0, 8'h00, 0, 0, 2'd0, 1, 0, 0, 0));
      step(mk(1'b1, 8'h00, 0, 1, 2'd3, 1, 0, 0, 0));
      step(mk(1'b1, 8'h00, 0, 1, 2'd3, 1, 0, 0, 0));
      step(mk(1'b1, 8'h00, 0, 1, 2'd3, 1, 0, 0, 0));

      // a stall one cycle short of the limit survives
      step(mk(1'b1, 8'hA5, 0, 0, 2'd0, 1, 0, 0, 0));
      step(mk(1'b1, 8'h01, 0, 0, 2'd0, 1, 0, 0, 0));
      step(mk(1'b1, 8'h00, 0, 0, 2'd0, 1, 0, 0, 0));
      step(mk(1'b1, 8'h13, 0, 0, 2'd0, 1, 0, 0, 0));
      step(mk(1'b1, 8'h00, 0, 0, 2'd0, 1, 0, 0, 0));
      for (int i = 0; i < TO - 1; i++)
         step(mk(1'b0, 8'h00, 0, 0, 2'd0, 1, 0, 0, 0));
      step(mk(1'b1, 8'h00, 0, 0, 2'd0, 1, 0, 0, 0));
      step(mk(1'b1, 8'h00, !CK, 0, 2'd0, CK, 1, 0, 32'h13));
      if (CK) step(mk(1'b1, 8'h13, 1, 0, 2'd0, 0, 0, 0, 0));

      // reset in the middle of a word
      step(mk(1'b1, 8'hA5, 0, 0, 2'd0, 1, 0, 0, 0));
      step(mk(1'b1, 8'h01, 0, 0, 2'd0, 1, 0, 0, 0));
      step(mk(1'b1, 8'h00, 0, 0, 2'd0, 1, 0, 0, 0));
      step(mk(1'b1, 8'h13, 0, 0, 2'd0, 1, 0, 0, 0));
      step(mk(1'b1, 8'h00, 0, 0, 2'd0, 1, 0, 0, 0));
      reset   = 1'b1;
      rx_data = 8'h00;
      @(posedge clk);
      #1;
      chk_reset("reset_midframe");
      reset = 1'b0;
      step(mk(1'b1, 8'h00, 0, 0, 2'd0, 1, 0, 0, 0));
      step(mk(1'b1, 8'hA5, 0, 0, 2'd0, 1, 0, 0, 0));
      frame1w(8'h13);

      rx_valid = 1'b0;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL pending_writes got=%0d want=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
